// File: rtl/em_pkg.sv
// -----------------------------------------------------------------------------
// em_pkg
// Shared definitions for the EX->MEM pipeline stage:
//   - RS_W          : width of the writeback-source select
//   - em_resultsrc_t: writeback-source encodings (ALU / MEM / PC+4)
//   - em_bundle_t   : packed EX->MEM payload at the core's default widths
//   - em_bundle_width(): payload width for arbitrary XLEN/RS_W/RD_W, used by
//                        the stage when it is built with non-default widths
// -----------------------------------------------------------------------------
package em_pkg;

  localparam int EM_XLEN = 32;
  localparam int EM_RD_W = 5;
  localparam int RS_W    = 2;

  typedef enum logic [RS_W-1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } em_resultsrc_t;

  // Field order here is the bit order of the flat payload vector used by the
  // stage, so a flat vector can be cast to this struct at default widths.
  typedef struct packed {
    logic                regwrite;
    logic [RS_W-1:0]     resultsrc;
    logic                memwrite;
    logic [EM_XLEN-1:0]  aluresult;
    logic [EM_XLEN-1:0]  writedata;
    logic [EM_RD_W-1:0]  rd;
    logic [EM_XLEN-1:0]  pcplus4;
  } em_bundle_t;

  localparam int EM_BUNDLE_W = $bits(em_bundle_t);

  // regwrite + resultsrc + memwrite + aluresult + writedata + rd + pcplus4
  function automatic int em_bundle_width(input int xlen, input int rs_w, input int rd_w);
    return 3 * xlen + rs_w + rd_w + 2;
  endfunction

endpackage

// File: rtl/em_skid_buf.sv
// -----------------------------------------------------------------------------
// em_skid_buf
// Generic-width valid/ready buffer carrying one EX->MEM payload vector.
//   SKID=1: two entries (main + skid); in_ready comes from a register, so
//           there is no combinational path from out_ready to in_ready.
//   SKID=0: one entry; in_ready = out_ready | ~out_valid.
// The main entry always drives out_data; the skid entry only absorbs the one
// word that arrives while the consumer is stalled.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : drop every held and incoming entry (next state EMPTY)
//   in_valid/in_ready/in_data   : upstream handshake + payload
//   out_valid/out_ready/out_data: downstream handshake + payload
// -----------------------------------------------------------------------------
module em_skid_buf #(
  parameter int W    = em_pkg::EM_BUNDLE_W,
  parameter bit SKID = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  logic [1:0]   state_reg, state_next;
  logic [W-1:0] main_reg, main_next;
  logic [W-1:0] skid_reg, skid_next;
  logic         accept;
  logic         consume;

  assign out_valid = (state_reg != ST_EMPTY);
  assign out_data  = main_reg;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  generate
    if (SKID) begin : g_skid
      logic ready_reg;

      always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        case (state_reg)
          ST_EMPTY: begin
            if (accept) begin
              state_next = ST_FULL;
              main_next  = in_data;
            end
          end
          ST_FULL: begin
            if (consume && accept) begin
              main_next = in_data;
            end else if (consume) begin
              state_next = ST_EMPTY;
            end else if (accept) begin
              // Consumer stalled while a new word arrived: park it.
              state_next = ST_SKID;
              skid_next  = in_data;
            end
          end
          ST_SKID: begin
            if (consume) begin
              state_next = ST_FULL;
              main_next  = skid_reg;
            end
          end
          default: state_next = ST_EMPTY;
        endcase
        // Clear wins over everything; payload may go stale, only state matters.
        if (clear) begin
          state_next = ST_EMPTY;
        end
      end

      // in_ready is the registered image of "next state has a free slot".
      // It resets low so nothing is accepted while rst is asserted, and rises
      // on the first clock edge after release.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ready_reg <= 1'b0;
        end else begin
          ready_reg <= (state_next != ST_SKID);
        end
      end

      assign in_ready = ready_reg;
    end else begin : g_single
      always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = '0;
        if (accept) begin
          // Covers both the empty case and accept+consume in the same cycle.
          state_next = ST_FULL;
          main_next  = in_data;
        end else if (consume) begin
          state_next = ST_EMPTY;
        end
        if (clear) begin
          state_next = ST_EMPTY;
        end
      end

      assign in_ready = out_ready | ~out_valid;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

endmodule

// File: rtl/em_pipe_stage.sv
// -----------------------------------------------------------------------------
// em_pipe_stage
// EX->MEM pipeline register with valid/ready handshake, flush-to-bubble,
// optional 2-entry skid buffer and a saturating back-pressure counter.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   flush                    : kill held and incoming entries this cycle
//   in_valid / in_ready      : handshake with the execute stage
//   *_e                      : execute-stage payload
//   out_valid / out_ready    : handshake with the memory stage
//   *_m                      : memory-stage payload (write enables gated by
//                              out_valid so a bubble never writes)
//   stall_cnt                : cycles spent with out_valid & ~out_ready,
//                              saturating, cleared only by rst
// -----------------------------------------------------------------------------
module em_pipe_stage #(
  parameter int XLEN  = 32,
  parameter int RD_W  = 5,
  parameter int RS_W  = em_pkg::RS_W,
  parameter bit SKID  = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             regwrite_e,
  input  logic [RS_W-1:0]  resultsrc_e,
  input  logic             memwrite_e,
  input  logic [XLEN-1:0]  aluresult_e,
  input  logic [XLEN-1:0]  writedata_e,
  input  logic [RD_W-1:0]  rd_e,
  input  logic [XLEN-1:0]  pcplus4_e,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             regwrite_m,
  output logic [RS_W-1:0]  resultsrc_m,
  output logic             memwrite_m,
  output logic [XLEN-1:0]  aluresult_m,
  output logic [XLEN-1:0]  writedata_m,
  output logic [RD_W-1:0]  rd_m,
  output logic [XLEN-1:0]  pcplus4_m,
  output logic [CNT_W-1:0] stall_cnt
);

  import em_pkg::*;

  localparam int BW = em_bundle_width(XLEN, RS_W, RD_W);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [BW-1:0]    in_bus;
  logic [BW-1:0]    out_bus;
  logic             buf_out_valid;
  logic             held_regwrite;
  logic             held_memwrite;
  logic [CNT_W-1:0] stall_reg;

  // Same field order as em_bundle_t.
  assign in_bus = {regwrite_e, resultsrc_e, memwrite_e,
                   aluresult_e, writedata_e, rd_e, pcplus4_e};

  em_skid_buf #(
    .W    (BW),
    .SKID (SKID)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_bus),
    .out_valid (buf_out_valid),
    .out_ready (out_ready),
    .out_data  (out_bus)
  );

  assign {held_regwrite, resultsrc_m, held_memwrite,
          aluresult_m, writedata_m, rd_m, pcplus4_m} = out_bus;

  // Flushed entries leave stale payload behind; gating the two write enables
  // with valid is what turns them into a harmless bubble downstream.
  assign out_valid  = buf_out_valid;
  assign regwrite_m = held_regwrite & buf_out_valid;
  assign memwrite_m = held_memwrite & buf_out_valid;

  // Counts every cycle the memory stage refuses a valid entry, including a
  // flush cycle; flush deliberately leaves the statistic alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_reg <= '0;
    end else if (buf_out_valid && !out_ready && (stall_reg != CNT_MAX)) begin
      stall_reg <= stall_reg + CNT_ONE;
    end
  end

  assign stall_cnt = stall_reg;

endmodule

// File: tb/tb_em_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_em_pipe_stage
// Directed bench for em_pipe_stage. Three instances share the same stimulus:
//   u_dut   : SKID=1, CNT_W=16  (scoreboarded payload path)
//   u_sat   : SKID=1, CNT_W=4   (counter saturation)
//   u_nskid : SKID=0            (combinational in_ready behaviour)
// -----------------------------------------------------------------------------
module tb_em_pipe_stage;

  import em_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic        regwrite_e;
  logic [1:0]  resultsrc_e;
  logic        memwrite_e;
  logic [31:0] aluresult_e;
  logic [31:0] writedata_e;
  logic [4:0]  rd_e;
  logic [31:0] pcplus4_e;

  logic        in_ready, out_valid, regwrite_m, memwrite_m;
  logic [1:0]  resultsrc_m;
  logic [31:0] aluresult_m, writedata_m, pcplus4_m;
  logic [4:0]  rd_m;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid, s_regwrite, s_memwrite;
  logic [1:0]  s_resultsrc;
  logic [31:0] s_alu, s_wd, s_pc;
  logic [4:0]  s_rd;
  logic [3:0]  s_stall;

  logic        n_in_ready, n_out_valid, n_regwrite, n_memwrite;
  logic [1:0]  n_resultsrc;
  logic [31:0] n_alu, n_wd, n_pc;
  logic [4:0]  n_rd;
  logic [15:0] n_stall;

  int          n_cmp;
  int          n_bad;
  int          exp_stall;
  em_bundle_t  sb[$];
  em_bundle_t  b;
  em_bundle_t  obs_b;
  em_bundle_t  exp_b;

  em_pipe_stage #(.XLEN(32), .RD_W(5), .RS_W(2), .SKID(1'b1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .regwrite_e(regwrite_e), .resultsrc_e(resultsrc_e), .memwrite_e(memwrite_e),
    .aluresult_e(aluresult_e), .writedata_e(writedata_e), .rd_e(rd_e), .pcplus4_e(pcplus4_e),
    .out_valid(out_valid), .out_ready(out_ready), .regwrite_m(regwrite_m),
    .resultsrc_m(resultsrc_m), .memwrite_m(memwrite_m), .aluresult_m(aluresult_m),
    .writedata_m(writedata_m), .rd_m(rd_m), .pcplus4_m(pcplus4_m), .stall_cnt(stall_cnt)
  );

  em_pipe_stage #(.XLEN(32), .RD_W(5), .RS_W(2), .SKID(1'b1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .regwrite_e(regwrite_e), .resultsrc_e(resultsrc_e), .memwrite_e(memwrite_e),
    .aluresult_e(aluresult_e), .writedata_e(writedata_e), .rd_e(rd_e), .pcplus4_e(pcplus4_e),
    .out_valid(s_out_valid), .out_ready(out_ready), .regwrite_m(s_regwrite),
    .resultsrc_m(s_resultsrc), .memwrite_m(s_memwrite), .aluresult_m(s_alu),
    .writedata_m(s_wd), .rd_m(s_rd), .pcplus4_m(s_pc), .stall_cnt(s_stall)
  );

  em_pipe_stage #(.XLEN(32), .RD_W(5), .RS_W(2), .SKID(1'b0), .CNT_W(16)) u_nskid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .regwrite_e(regwrite_e), .resultsrc_e(resultsrc_e), .memwrite_e(memwrite_e),
    .aluresult_e(aluresult_e), .writedata_e(writedata_e), .rd_e(rd_e), .pcplus4_e(pcplus4_e),
    .out_valid(n_out_valid), .out_ready(out_ready), .regwrite_m(n_regwrite),
    .resultsrc_m(n_resultsrc), .memwrite_m(n_memwrite), .aluresult_m(n_alu),
    .writedata_m(n_wd), .rd_m(n_rd), .pcplus4_m(n_pc), .stall_cnt(n_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic em_bundle_t mk(input logic [31:0] a);
    em_bundle_t r;
    r.regwrite = a[0];
    case (a % 32'd3)
      32'd0:   r.resultsrc = RES_ALU;
      32'd1:   r.resultsrc = RES_MEM;
      default: r.resultsrc = RES_PC4;
    endcase
    r.memwrite  = a[1];
    r.aluresult = a;
    r.writedata = ~a;
    r.rd        = a[4:0] ^ 5'h15;
    r.pcplus4   = (a << 2) + 32'd4;
    return r;
  endfunction

  task automatic drive(input em_bundle_t d);
    regwrite_e  = d.regwrite;
    resultsrc_e = d.resultsrc;
    memwrite_e  = d.memwrite;
    aluresult_e = d.aluresult;
    writedata_e = d.writedata;
    rd_e        = d.rd;
    pcplus4_e   = d.pcplus4;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: at the negedge, any word the memory stage takes this cycle is
  // popped from the scoreboard and compared; returns 1 ns after the posedge.
  task automatic tick();
    @(negedge clk);
    if (out_valid && out_ready && !flush) begin
      obs_b = {regwrite_m, resultsrc_m, memwrite_m, aluresult_m, writedata_m, rd_m, pcplus4_m};
      if (sb.size() == 0) begin
        check("unexpected_out", 128'(sb.size()), 128'(1));
      end else begin
        exp_b = sb.pop_front();
        check("payload", 128'(obs_b), 128'(exp_b));
        $display("consume alu=%08h", obs_b.aluresult);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_stall = 0;

    // Reset with every input driven high.
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    b = '1;
    drive(b);
    #12;
    obs_b = {regwrite_m, resultsrc_m, memwrite_m, aluresult_m, writedata_m, rd_m, pcplus4_m};
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_bundle", 128'(obs_b), 128'(0));
    check("rst_stall", 128'(stall_cnt), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(0));

    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    b = '0;
    drive(b);
    tick();
    check("rel_in_ready", 128'(in_ready), 128'(1));

    // Streaming: 1, 2, 3 back to back with the memory stage always ready.
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      b = mk(32'(i));
      drive(b);
      in_valid = 1'b1;
      sb.push_back(b);
      $display("send alu=%08h", b.aluresult);
      #1;
      check("stream_in_ready", 128'(in_ready), 128'(1));
      if (i > 1) check("stream_no_bubble", 128'(out_valid), 128'(1));
      tick();
    end
    in_valid = 1'b0;
    check("stream_last_valid", 128'(out_valid), 128'(1));
    tick();
    check("stream_drained", 128'(out_valid), 128'(0));
    check("stream_stall", 128'(stall_cnt), 128'(exp_stall));

    // Back-pressure: A accepted, then B lands in the skid entry.
    b = mk(32'h10);
    drive(b);
    in_valid = 1'b1;
    sb.push_back(b);
    $display("send alu=%08h", b.aluresult);
    tick();
    out_ready = 1'b0;
    b = mk(32'h20);
    drive(b);
    sb.push_back(b);
    $display("send alu=%08h", b.aluresult);
    #1;
    check("nskid_ready_low", 128'(n_in_ready), 128'(0));
    tick();
    exp_stall++;
    in_valid = 1'b0;
    check("bp_in_ready", 128'(in_ready), 128'(0));
    check("bp_out_valid", 128'(out_valid), 128'(1));
    check("bp_hold_alu", 128'(aluresult_m), 128'(32'h10));
    check("bp_stall", 128'(stall_cnt), 128'(exp_stall));
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_stall++;
      check("bp_hold_alu", 128'(aluresult_m), 128'(32'h10));
      check("bp_hold_ready", 128'(in_ready), 128'(0));
      check("bp_stall", 128'(stall_cnt), 128'(exp_stall));
    end

    // Release: main DUT drains A then B; single-entry DUT accepts and
    // consumes in the same cycle.
    out_ready = 1'b1;
    in_valid = 1'b1;
    b = mk(32'h30);
    drive(b);
    #1;
    check("nskid_ready_comb", 128'(n_in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    check("nskid_swap_valid", 128'(n_out_valid), 128'(1));
    check("nskid_swap_alu", 128'(n_alu), 128'(32'h30));
    check("bp_refill_ready", 128'(in_ready), 128'(1));
    tick();
    check("bp_drained", 128'(sb.size()), 128'(0));

    // Fill both entries with writing instructions, then stall 20 cycles.
    b = mk(32'h41);
    b.regwrite = 1'b1;
    b.memwrite = 1'b1;
    drive(b);
    in_valid = 1'b1;
    sb.push_back(b);
    $display("send alu=%08h", b.aluresult);
    tick();
    out_ready = 1'b0;
    b = mk(32'h42);
    b.regwrite = 1'b1;
    b.memwrite = 1'b1;
    drive(b);
    sb.push_back(b);
    $display("send alu=%08h", b.aluresult);
    tick();
    exp_stall++;
    in_valid = 1'b0;
    check("skid_regwrite", 128'(regwrite_m), 128'(1));
    check("skid_memwrite", 128'(memwrite_m), 128'(1));
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_stall++;
    end
    check("sat_stall", 128'(s_stall), 128'(15));
    check("long_stall", 128'(stall_cnt), 128'(exp_stall));
    check("long_hold_alu", 128'(aluresult_m), 128'(32'h41));

    // Flush with a new instruction presented: everything disappears.
    flush = 1'b1;
    in_valid = 1'b1;
    b = mk(32'h55);
    drive(b);
    $display("flush with alu=%08h presented", b.aluresult);
    tick();
    exp_stall++;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    check("flush_out_valid", 128'(out_valid), 128'(0));
    check("flush_regwrite", 128'(regwrite_m), 128'(0));
    check("flush_memwrite", 128'(memwrite_m), 128'(0));
    check("flush_in_ready", 128'(in_ready), 128'(1));
    check("flush_keeps_stall", 128'(stall_cnt), 128'(exp_stall));
    check("flush_keeps_sat", 128'(s_stall), 128'(15));
    out_ready = 1'b1;
    tick();
    check("flush_no_ghost", 128'(out_valid), 128'(0));

    // Asynchronous reset in the middle of a cycle with a held entry.
    out_ready = 1'b0;
    b = mk(32'h66);
    drive(b);
    in_valid = 1'b1;
    sb.push_back(b);
    $display("send alu=%08h", b.aluresult);
    tick();
    in_valid = 1'b0;
    check("pre_arst_valid", 128'(out_valid), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    check("arst_out_valid", 128'(out_valid), 128'(0));
    check("arst_alu", 128'(aluresult_m), 128'(0));
    check("arst_stall", 128'(stall_cnt), 128'(0));
    check("arst_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("arst_rel_ready", 128'(in_ready), 128'(1));
    check("final_sb_empty", 128'(sb.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
